// File: rtl/psk_mapper_if.sv
// Bit-in / I-Q-out stream bundle for the PSK mapper.
// master = bit source and sample sink, slave = mapper.
interface psk_mapper_if #(
  parameter int WIDTH = 16
);
  logic                    mode;
  logic                    bit_tdata;
  logic                    bit_tvalid;
  logic                    bit_tready;
  logic signed [WIDTH-1:0] I_tdata;
  logic signed [WIDTH-1:0] Q_tdata;
  logic                    tvalid;
  logic                    tready;

  modport master (
    output mode, bit_tdata, bit_tvalid, tready,
    input  bit_tready, I_tdata, Q_tdata, tvalid
  );

  modport slave (
    input  mode, bit_tdata, bit_tvalid, tready,
    output bit_tready, I_tdata, Q_tdata, tvalid
  );
endinterface

// File: rtl/psk_mapper.sv
// Transmit PSK mapper: packs serial bits into BPSK/QPSK symbols and holds
// each mapped I/Q pair for SPS output samples. Negative axis <=> bit 1.
module psk_mapper #(
  parameter int WIDTH = 16,
  parameter int AMP   = 8192,
  parameter int SPS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  psk_mapper_if.slave bus
);
  localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CW-1:0]           LAST = CW'(SPS - 1);
  localparam logic signed [WIDTH-1:0] POS  = WIDTH'(AMP);
  localparam logic signed [WIDTH-1:0] NEG  = -POS;

  // assembly stage
  logic [1:0]              r_nxt_bits;
  logic [1:0]              r_nxt_cnt;
  logic                    r_nxt_mode;
  // emit stage
  logic signed [WIDTH-1:0] r_cur_I;
  logic signed [WIDTH-1:0] r_cur_Q;
  logic                    r_cur_valid;
  logic [CW-1:0]           r_samp_cnt;

  logic                    w_nxt_full;
  logic                    w_bit_acc;
  logic                    w_samp_acc;
  logic                    w_last_acc;
  logic                    w_load;
  logic signed [WIDTH-1:0] w_map_I;
  logic signed [WIDTH-1:0] w_map_Q;

  // Symbol is complete once it holds as many bits as its latched mode needs.
  assign w_nxt_full = (r_nxt_cnt == 2'd1 && !r_nxt_mode) ||
                      (r_nxt_cnt == 2'd2 &&  r_nxt_mode);

  // Ready depends on registered state only, so no path from downstream tready.
  assign bus.bit_tready = !rst && !w_nxt_full;

  assign w_bit_acc  = bus.bit_tvalid && bus.bit_tready;
  assign w_samp_acc = r_cur_valid && bus.tready;
  assign w_last_acc = w_samp_acc && (r_samp_cnt == LAST);
  assign w_load     = w_nxt_full && (!r_cur_valid || w_last_acc);

  assign w_map_I = r_nxt_bits[1] ? NEG : POS;
  assign w_map_Q = !r_nxt_mode ? '0 : (r_nxt_bits[0] ? NEG : POS);

  assign bus.tvalid  = r_cur_valid;
  assign bus.I_tdata = r_cur_valid ? r_cur_I : '0;
  assign bus.Q_tdata = r_cur_valid ? r_cur_Q : '0;

  // Assembly: collect bits MSB first; mode is frozen at the first bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nxt_bits <= '0;
      r_nxt_cnt  <= '0;
      r_nxt_mode <= 1'b0;
    end else if (w_load) begin
      r_nxt_cnt <= '0;
    end else if (w_bit_acc) begin
      if (r_nxt_cnt == 2'd0) begin
        r_nxt_mode    <= bus.mode;
        r_nxt_bits[1] <= bus.bit_tdata;
      end else begin
        r_nxt_bits[0] <= bus.bit_tdata;
      end
      r_nxt_cnt <= r_nxt_cnt + 2'd1;
    end
  end

  // Emit: hold the symbol for SPS accepted samples, chain or underrun at end.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_I     <= '0;
      r_cur_Q     <= '0;
      r_cur_valid <= 1'b0;
      r_samp_cnt  <= '0;
    end else if (w_load) begin
      r_cur_I     <= w_map_I;
      r_cur_Q     <= w_map_Q;
      r_cur_valid <= 1'b1;
      r_samp_cnt  <= '0;
    end else if (w_samp_acc) begin
      if (r_samp_cnt != LAST) begin
        r_samp_cnt <= r_samp_cnt + 1'b1;
      end else begin
        r_cur_valid <= 1'b0;
        r_samp_cnt  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_psk_mapper.sv
// Directed bench for psk_mapper (WIDTH=16, AMP=8192, SPS=4).
module tb_psk_mapper;
  localparam int WIDTH = 16;
  localparam logic signed [15:0] POS = 16'sd8192;
  localparam logic signed [15:0] NEG = -16'sd8192;
  localparam logic signed [15:0] ZER = 16'sd0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  psk_mapper_if #(.WIDTH(WIDTH)) bus ();

  psk_mapper #(.WIDTH(WIDTH), .AMP(8192), .SPS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // advance one edge, then settle 1 time unit
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present one bit and return just after the edge that accepts it
  task automatic send_bit(input logic b, input logic m);
    bit done = 1'b0;
    bus.bit_tdata  = b;
    bus.mode       = m;
    bus.bit_tvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus.bit_tready) done = 1'b1;
      step();
    end
    bus.bit_tvalid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_bit_timeout: bit_tready=%0b required 1 within 50 cycles", bus.bit_tready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (bus.tvalid !== 1'b0 || bus.bit_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: tvalid=%0b bit_tready=%0b required 0 0", bus.tvalid, bus.bit_tready);
    end
    checks++;
    if (bus.I_tdata !== ZER || bus.Q_tdata !== ZER) begin
      errors++;
      $display("FAIL reset_iq: I=%0d Q=%0d required 0 0", bus.I_tdata, bus.Q_tdata);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.bit_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: bit_tready=%0b required 1", bus.bit_tready);
    end
  endtask

  task automatic test_bpsk();
    send_bit(1'b0, 1'b0);
    checks++;
    if (bus.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL bpsk_latency_early: tvalid=%0b required 0 one edge after accept", bus.tvalid);
    end
    fork
      send_bit(1'b1, 1'b0);
      begin
        for (int i = 0; i < 8; i++) begin
          step();
          checks++;
          if (bus.tvalid !== 1'b1 || bus.I_tdata !== (i < 4 ? POS : NEG) || bus.Q_tdata !== ZER) begin
            errors++;
            $display("FAIL bpsk_sample%0d: tvalid=%0b I=%0d Q=%0d required 1 %0d 0",
                     i, bus.tvalid, bus.I_tdata, bus.Q_tdata, (i < 4 ? POS : NEG));
          end
        end
      end
    join
    step();
    checks++;
    if (bus.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL bpsk_drain: tvalid=%0b required 0", bus.tvalid);
    end
  endtask

  task automatic test_qpsk();
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    checks++;
    if (bus.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL qpsk_latency_early: tvalid=%0b required 0", bus.tvalid);
    end
    fork
      begin
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
      end
      begin
        for (int i = 0; i < 8; i++) begin
          step();
          checks++;
          if (bus.tvalid !== 1'b1 || bus.I_tdata !== (i < 4 ? NEG : POS) ||
              bus.Q_tdata !== (i < 4 ? POS : NEG)) begin
            errors++;
            $display("FAIL qpsk_sample%0d: tvalid=%0b I=%0d Q=%0d required 1 %0d %0d",
                     i, bus.tvalid, bus.I_tdata, bus.Q_tdata, (i < 4 ? NEG : POS), (i < 4 ? POS : NEG));
          end
          if (i == 0 || i == 4) begin
            checks++;
            if ({bus.I_tdata < 0, bus.Q_tdata < 0} !== (i == 0 ? 2'b10 : 2'b01)) begin
              errors++;
              $display("FAIL qpsk_detect%0d: signs=%b required %b", i,
                       {bus.I_tdata < 0, bus.Q_tdata < 0}, (i == 0 ? 2'b10 : 2'b01));
            end
          end
        end
      end
    join
    step();
    checks++;
    if (bus.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL qpsk_drain: tvalid=%0b required 0", bus.tvalid);
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] pat = 6'b111001; // bit j drives slot j: 1,0,0,1,1,1
    int acc = 0;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    step();
    for (int j = 0; j < 6; j++) begin
      bus.tready = pat[j];
      #1;
      checks++;
      if (bus.tvalid !== 1'b1 || bus.I_tdata !== NEG || bus.Q_tdata !== NEG) begin
        errors++;
        $display("FAIL bp_hold%0d: tvalid=%0b I=%0d Q=%0d required 1 %0d %0d",
                 j, bus.tvalid, bus.I_tdata, bus.Q_tdata, NEG, NEG);
      end
      if (bus.tvalid && bus.tready) acc++;
      step();
    end
    bus.tready = 1'b1;
    #1;
    checks++;
    if (acc != 4 || bus.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_count: accepted=%0d tvalid=%0b required 4 0", acc, bus.tvalid);
    end
  endtask

  task automatic test_underrun();
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.tvalid !== 1'b1 || bus.I_tdata !== NEG || bus.Q_tdata !== ZER) begin
        errors++;
        $display("FAIL under_sample%0d: tvalid=%0b I=%0d Q=%0d required 1 %0d 0",
                 i, bus.tvalid, bus.I_tdata, bus.Q_tdata, NEG);
      end
    end
    step();
    checks++;
    if (bus.tvalid !== 1'b0 || bus.I_tdata !== ZER || bus.Q_tdata !== ZER) begin
      errors++;
      $display("FAIL under_idle: tvalid=%0b I=%0d Q=%0d required 0 0 0", bus.tvalid, bus.I_tdata, bus.Q_tdata);
    end
    step();
    step();
    send_bit(1'b0, 1'b0);
    checks++;
    if (bus.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL under_restart_early: tvalid=%0b required 0", bus.tvalid);
    end
    step();
    checks++;
    if (bus.tvalid !== 1'b1 || bus.I_tdata !== POS || bus.Q_tdata !== ZER) begin
      errors++;
      $display("FAIL under_restart: tvalid=%0b I=%0d Q=%0d required 1 %0d 0", bus.tvalid, bus.I_tdata, bus.Q_tdata, POS);
    end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (bus.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL under_restart_drain: tvalid=%0b required 0", bus.tvalid);
    end
  endtask

  task automatic test_mode_flip();
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.tvalid !== 1'b1 || bus.I_tdata !== NEG || bus.Q_tdata !== POS) begin
        errors++;
        $display("FAIL mode_sample%0d: tvalid=%0b I=%0d Q=%0d required 1 %0d %0d",
                 i, bus.tvalid, bus.I_tdata, bus.Q_tdata, NEG, POS);
      end
    end
    step();
    checks++;
    if (bus.tvalid !== 1'b0 || bus.bit_tready !== 1'b1) begin
      errors++;
      $display("FAIL mode_drain: tvalid=%0b bit_tready=%0b required 0 1", bus.tvalid, bus.bit_tready);
    end
  endtask

  task automatic test_reset_mid();
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    step();
    bus.tready = 1'b0;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    checks++;
    if (bus.bit_tready !== 1'b0 || bus.I_tdata !== POS || bus.Q_tdata !== POS) begin
      errors++;
      $display("FAIL rstmid_setup: bit_tready=%0b I=%0d Q=%0d required 0 %0d %0d",
               bus.bit_tready, bus.I_tdata, bus.Q_tdata, POS, POS);
    end
    bus.tready = 1'b1;
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.bit_tready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ready_comb: bit_tready=%0b required 0", bus.bit_tready);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.tvalid !== 1'b0 || bus.bit_tready !== 1'b0 || bus.I_tdata !== ZER) begin
        errors++;
        $display("FAIL rstmid_during%0d: tvalid=%0b bit_tready=%0b I=%0d required 0 0 0",
                 i, bus.tvalid, bus.bit_tready, bus.I_tdata);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.bit_tready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_release: bit_tready=%0b required 1", bus.bit_tready);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (bus.tvalid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_stale%0d: tvalid=%0b required 0", i, bus.tvalid);
      end
    end
  endtask

  initial begin
    bus.mode       = 1'b0;
    bus.bit_tdata  = 1'b0;
    bus.bit_tvalid = 1'b0;
    bus.tready     = 1'b1;
    test_reset();
    test_bpsk();
    test_qpsk();
    test_backpressure();
    test_underrun();
    test_mode_flip();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
